// File: rtl/serial_sub_two_values_pkg.sv
// Shared definitions for the bit-serial subtractor: default operand width
// and the controller state encoding.
package serial_sub_two_values_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_two_values_if.sv
// Start/busy/done handshake bundle of the serial subtractor, plus a debug view
// of the controller state.
interface serial_sub_two_values_if
    import serial_sub_two_values_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    // Handshake: start is sampled only while idle. busy covers RUN and DONE.
    // done is a one-cycle pulse during which diff/borrow/ovf are fresh.
    // Results then hold until the next done.
    logic             start;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic [1:0]       state;

    modport master (
        output start, ain, bin,
        input  busy, done, diff, borrow, ovf, state
    );

    modport slave (
        input  start, ain, bin,
        output busy, done, diff, borrow, ovf, state
    );

endinterface

// File: rtl/serial_sub_two_values_full_sub_bit.sv
// One-bit full subtractor cell: d = a - b - bin_in, with borrow out.
// It is the borrow-based counterpart of the full-adder cell.
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin_in,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin_in;
    assign bout = (~a & b) | (~(a ^ b) & bin_in);

endmodule

// File: rtl/serial_sub_two_values.sv
// Bit-serial subtractor: processes ain - bin LSB first, one bit per clock.
// A start/busy/done handshake controls it.
module serial_sub_two_values
    import serial_sub_two_values_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_sub_two_values_if.slave  bus
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_borrow;
    logic             r_ovf;
    logic             w_d;
    logic             w_bout;
    logic             w_last;

    full_sub_bit u_cell (
        .a      (r_a[0]),
        .b      (r_b[0]),
        .bin_in (r_br),
        .d      (w_d),
        .bout   (w_bout)
    );

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The operand registers shift right, so bit 0 is always the bit in flight.
    // On the last step, bit 0 holds the original MSBs used for the overflow test.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.ain;
                        r_b   <= bus.bin;
                        r_br  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_a  <= r_a >> 1;
                    r_b  <= r_b >> 1;
                    r_br <= w_bout;
                    r_sh <= {w_d, r_sh[WIDTH-1:1]};
                    if (w_last) begin
                        r_diff   <= {w_d, r_sh[WIDTH-1:1]};
                        r_borrow <= w_bout;
                        r_ovf    <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;
    assign bus.ovf    = r_ovf;
    assign bus.state  = r_state;

endmodule

// File: tb/tb_serial_sub_two_values.sv
// Directed and exhaustive bench for the 4-bit serial subtractor.
// Expected results are queued at launch and checked on the done pulse.
module tb_serial_sub_two_values;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [W+1:0] exp_q[$];

    serial_sub_two_values_if #(.WIDTH(W)) bus ();

    serial_sub_two_values #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result packed as {ovf, borrow, diff}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        d  = a - b;
        br = (a < b);
        ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        return {ov, br, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. It launches one op and checks busy/done for six cycles.
    // It returns at the negedge after the IDLE edge, so the next launch is at the earliest edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        logic [W+1:0] exp;
        exp = '0;
        bus.ain   = a;
        bus.bin   = b;
        bus.start = 1'b1;
        exp_q.push_back(model(a, b));
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 0 && !hold) bus.start = 1'b0;
            if (hold && c <= 3) begin
                bus.ain = W'($urandom_range(0, 15));
                bus.bin = W'($urandom_range(0, 15));
            end
            chk("busy", {31'd0, bus.busy}, {31'd0, (c <= 4)});
            chk("done", {31'd0, bus.done}, {31'd0, (c == 4)});
            if (c == 4) begin
                if (exp_q.size() == 0) begin
                    chk("queue_nonempty", 32'd0, 32'd1);
                end else begin
                    exp = exp_q.pop_front();
                    chk("result", {26'd0, bus.ovf, bus.borrow, bus.diff}, {26'd0, exp});
                end
            end
            if (c == 5) chk("result_hold", {26'd0, bus.ovf, bus.borrow, bus.diff}, {26'd0, exp});
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.ain   = '0;
        bus.bin   = '0;

        #2 rst = 1'b1;
        #3;
        chk("rst_busy",  {31'd0, bus.busy},   32'd0);
        chk("rst_done",  {31'd0, bus.done},   32'd0);
        chk("rst_diff",  {28'd0, bus.diff},   32'd0);
        chk("rst_bor",   {31'd0, bus.borrow}, 32'd0);
        chk("rst_ovf",   {31'd0, bus.ovf},    32'd0);
        chk("rst_state", {30'd0, bus.state},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(4'd9,  4'd3, 1'b0);
        do_op(4'd3,  4'd9, 1'b0);
        do_op(4'd0,  4'd1, 1'b0);
        do_op(4'd8,  4'd1, 1'b0);
        do_op(4'hF,  4'hF, 1'b0);

        // start held high with operands scrambled mid-run, then the earliest follow-on op
        do_op(4'd9,  4'd3, 1'b1);
        do_op(4'd12, 4'd5, 1'b0);

        // Abort mid-run with cnt=2. No result is queued for this op.
        bus.ain   = 4'd11;
        bus.bin   = 4'd6;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy",  {31'd0, bus.busy},   32'd0);
        chk("abort_done",  {31'd0, bus.done},   32'd0);
        chk("abort_diff",  {28'd0, bus.diff},   32'd0);
        chk("abort_bor",   {31'd0, bus.borrow}, 32'd0);
        chk("abort_ovf",   {31'd0, bus.ovf},    32'd0);
        chk("abort_state", {30'd0, bus.state},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_abort_done", {31'd0, bus.done}, 32'd0);
            chk("post_abort_busy", {31'd0, bus.busy}, 32'd0);
        end
        do_op(4'd5, 4'd5, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(W'(a), W'(b), 1'b0);
            end
        end

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
